// File: rtl/bram_arb2_rv.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | bram_arb2_rv : two-port ready/valid BRAM, one access per cycle, with a   |
// |                one-entry read-response slot per port.                    |
// | Option: BRAM_ARB_RR_EN selects round-robin tie-break (else port 1 wins). |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module bram_arb2_rv #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,

  input  logic                      i_req_valid_0,
  output logic                      o_req_ready_0,
  input  logic                      i_req_write_0,
  input  logic [ADDR_WIDTH-1:0]     i_req_addr_0,
  input  logic [DATA_WIDTH-1:0]     i_req_data_0,
  input  logic [DATA_WIDTH/8-1:0]   i_req_be_0,
  output logic                      o_rsp_valid_0,
  input  logic                      i_rsp_ready_0,
  output logic [DATA_WIDTH-1:0]     o_rsp_data_0,

  input  logic                      i_req_valid_1,
  output logic                      o_req_ready_1,
  input  logic                      i_req_write_1,
  input  logic [ADDR_WIDTH-1:0]     i_req_addr_1,
  input  logic [DATA_WIDTH-1:0]     i_req_data_1,
  input  logic [DATA_WIDTH/8-1:0]   i_req_be_1,
  output logic                      o_rsp_valid_1,
  input  logic                      i_rsp_ready_1,
  output logic [DATA_WIDTH-1:0]     o_rsp_data_1
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  rsp_valid_0_q, rsp_valid_0_d;
  logic                  rsp_valid_1_q, rsp_valid_1_d;
  logic [DATA_WIDTH-1:0] rsp_data_0_q;
  logic [DATA_WIDTH-1:0] rsp_data_1_q;

  logic                  w_elig_0, w_elig_1, w_tie;
  logic                  w_gnt_0, w_gnt_1;
  logic                  w_rd_0, w_rd_1, w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [BE_WIDTH-1:0]   w_be;

`ifdef BRAM_ARB_RR_EN
  logic last_q, last_d;  // 1 = port 1 won the most recent tie

  always_comb begin
    last_d = last_q;
    if (w_tie) last_d = w_gnt_1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end
`endif

  // A read may only enter when its slot is free or being emptied this cycle.
  always_comb begin
    w_elig_0 = i_req_valid_0 & (i_req_write_0 | ~rsp_valid_0_q | i_rsp_ready_0);
    w_elig_1 = i_req_valid_1 & (i_req_write_1 | ~rsp_valid_1_q | i_rsp_ready_1);
    w_tie    = i_rst_n & w_elig_0 & w_elig_1;
    w_gnt_0  = 1'b0;
    w_gnt_1  = 1'b0;
    if (w_tie) begin
`ifdef BRAM_ARB_RR_EN
      w_gnt_0 = last_q;
      w_gnt_1 = ~last_q;
`else
      w_gnt_1 = 1'b1;
`endif
    end else if (i_rst_n) begin
      w_gnt_0 = w_elig_0;
      w_gnt_1 = w_elig_1;
    end
  end

  assign w_rd_0  = w_gnt_0 & ~i_req_write_0;
  assign w_rd_1  = w_gnt_1 & ~i_req_write_1;
  assign w_we    = (w_gnt_0 & i_req_write_0) | (w_gnt_1 & i_req_write_1);
  assign w_addr  = w_gnt_1 ? i_req_addr_1 : i_req_addr_0;
  assign w_wdata = w_gnt_1 ? i_req_data_1 : i_req_data_0;
  assign w_be    = w_gnt_1 ? i_req_be_1   : i_req_be_0;

  always_ff @(posedge i_clk) begin
    if (w_we) begin
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (w_be[k]) mem_q[w_addr][8*k +: 8] <= w_wdata[8*k +: 8];
      end
    end
  end

  always_comb begin
    rsp_valid_0_d = rsp_valid_0_q;
    rsp_valid_1_d = rsp_valid_1_q;
    if (rsp_valid_0_q & i_rsp_ready_0) rsp_valid_0_d = 1'b0;
    if (rsp_valid_1_q & i_rsp_ready_1) rsp_valid_1_d = 1'b0;
    if (w_rd_0) rsp_valid_0_d = 1'b1;
    if (w_rd_1) rsp_valid_1_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rsp_valid_0_q <= 1'b0;
      rsp_valid_1_q <= 1'b0;
      rsp_data_0_q  <= '0;
      rsp_data_1_q  <= '0;
    end else begin
      rsp_valid_0_q <= rsp_valid_0_d;
      rsp_valid_1_q <= rsp_valid_1_d;
      if (w_rd_0) rsp_data_0_q <= mem_q[w_addr];
      if (w_rd_1) rsp_data_1_q <= mem_q[w_addr];
    end
  end

  assign o_req_ready_0 = w_gnt_0;
  assign o_req_ready_1 = w_gnt_1;
  assign o_rsp_valid_0 = rsp_valid_0_q;
  assign o_rsp_valid_1 = rsp_valid_1_q;
  assign o_rsp_data_0  = rsp_data_0_q;
  assign o_rsp_data_1  = rsp_data_1_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_arb2_rv.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bram_arb2_rv : randomized bench for bram_arb2_rv with a behavioural   |
// |                   memory/slot model and literal directed expectations.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_bram_arb2_rv;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid, req_write, req_ready, rsp_valid, rsp_ready;
  logic [1:0][9:0]   req_addr;
  logic [1:0][31:0]  req_data, rsp_data;
  logic [1:0][3:0]   req_be;

  bram_arb2_rv #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req_valid_0 (req_valid[0]),
    .o_req_ready_0 (req_ready[0]),
    .i_req_write_0 (req_write[0]),
    .i_req_addr_0  (req_addr[0]),
    .i_req_data_0  (req_data[0]),
    .i_req_be_0    (req_be[0]),
    .o_rsp_valid_0 (rsp_valid[0]),
    .i_rsp_ready_0 (rsp_ready[0]),
    .o_rsp_data_0  (rsp_data[0]),
    .i_req_valid_1 (req_valid[1]),
    .o_req_ready_1 (req_ready[1]),
    .i_req_write_1 (req_write[1]),
    .i_req_addr_1  (req_addr[1]),
    .i_req_data_1  (req_data[1]),
    .i_req_be_1    (req_be[1]),
    .o_rsp_valid_1 (rsp_valid[1]),
    .i_rsp_ready_1 (rsp_ready[1]),
    .o_rsp_data_1  (rsp_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- behavioural model ----------------
  logic [31:0]      m_mem   [1024];
  bit               m_known [1024];
  logic [1:0]       m_sv, m_sk, m_zero;
  logic [1:0][31:0] m_sd;
  bit               m_last;   // 1 = port 1 won the last tie
  bit               live = 0;

  int n_vec = 0;
  int n_err = 0;

  logic        lit_en  [4];
  int          lit_sel [4];
  logic [31:0] lit_exp [4];

  function automatic logic [31:0] pat(input logic [9:0] a);
    return {16'hC0DE, 6'b0, a};
  endfunction

  function automatic logic [1:0] melig();
    logic [1:0] e;
    for (int p = 0; p < 2; p++)
      e[p] = req_valid[p] & (req_write[p] | ~m_sv[p] | rsp_ready[p]);
    return e;
  endfunction

  function automatic logic [1:0] mgrant();
    logic [1:0] e;
    e = melig();
    if (rst_n !== 1'b1) return 2'b00;
    if (e == 2'b11) begin
`ifdef BRAM_ARB_RR_EN
      return m_last ? 2'b01 : 2'b10;
`else
      return 2'b10;
`endif
    end
    return e;
  endfunction

  always @(posedge clk) begin : b_model
    logic [1:0] e, g;
    if (rst_n === 1'b0) begin
      live   = 1;
      m_sv   = 2'b00;
      m_zero = 2'b11;
      m_last = 1;
    end else if (live) begin
      e = melig();
      g = mgrant();
      for (int p = 0; p < 2; p++) begin
        if (g[p] && !req_write[p]) begin
          m_sv[p]   = 1'b1;
          m_sd[p]   = m_mem[req_addr[p]];
          m_sk[p]   = m_known[req_addr[p]];
          m_zero[p] = 1'b0;
        end else if (m_sv[p] && rsp_ready[p]) begin
          m_sv[p] = 1'b0;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (g[p] && req_write[p]) begin
          for (int k = 0; k < 4; k++)
            if (req_be[p][k]) m_mem[req_addr[p]][8*k +: 8] = req_data[p][8*k +: 8];
          if (req_be[p] == 4'hF) m_known[req_addr[p]] = 1;
        end
      end
      if (e == 2'b11) m_last = g[1];
    end
  end

  function automatic logic [31:0] sel_val(input int s);
    case (s)
      0: return 32'(req_ready[0]);
      1: return 32'(req_ready[1]);
      2: return 32'(rsp_valid[0]);
      3: return 32'(rsp_valid[1]);
      4: return rsp_data[0];
      default: return rsp_data[1];
    endcase
  endfunction

  function automatic string sel_name(input int s);
    case (s)
      0: return "lit_req_ready_0";
      1: return "lit_req_ready_1";
      2: return "lit_rsp_valid_0";
      3: return "lit_rsp_valid_1";
      4: return "lit_rsp_data_0";
      default: return "lit_rsp_data_1";
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : b_compare
    logic [1:0] g;
    if (live) begin
      g = mgrant();
      chk("req_ready_0", 32'(req_ready[0]), 32'(g[0]));
      chk("req_ready_1", 32'(req_ready[1]), 32'(g[1]));
      chk("rsp_valid_0", 32'(rsp_valid[0]), 32'(m_sv[0]));
      chk("rsp_valid_1", 32'(rsp_valid[1]), 32'(m_sv[1]));
      if (m_zero[0])                chk("rsp_data_0", rsp_data[0], 32'h0);
      else if (m_sv[0] && m_sk[0])  chk("rsp_data_0", rsp_data[0], m_sd[0]);
      if (m_zero[1])                chk("rsp_data_1", rsp_data[1], 32'h0);
      else if (m_sv[1] && m_sk[1])  chk("rsp_data_1", rsp_data[1], m_sd[1]);
      for (int i = 0; i < 4; i++)
        if (lit_en[i]) chk(sel_name(lit_sel[i]), sel_val(lit_sel[i]), lit_exp[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic post(input int i, input int s, input logic [31:0] v);
    lit_en[i] = 1; lit_sel[i] = s; lit_exp[i] = v;
  endtask

  task automatic clear_lits();
    for (int i = 0; i < 4; i++) lit_en[i] = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_req(input int p, input logic wr, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    logic acc;
    acc = 0;
    req_valid[p] = 1; req_write[p] = wr; req_addr[p] = a; req_data[p] = d; req_be[p] = be;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      acc = req_ready[p];
      step();
      if (acc) break;
    end
    req_valid[p] = 0;
    if (!acc) begin
      $display("FAIL req_timeout port %0d addr %h: got no accept, want accept", p, a);
      $fatal(1, "request timeout");
    end
  endtask

  task automatic do_read_lit(input int p, input logic [9:0] a, input logic [31:0] exp);
    do_req(p, 1'b0, a, 32'h0, 4'h0);
    post(0, 2 + p, 32'd1);
    post(1, 4 + p, exp);
    step();
    clear_lits();
  endtask

  initial begin : b_drive
    logic [1:0] want, pend, acc;
    clear_lits();
    rst_n = 0; req_valid = 0; req_write = 0; rsp_ready = 2'b11;
    req_addr = '0; req_data = '0; req_be = '0;
    step(); step();
    rst_n = 1;

    for (int a = 0; a < 1024; a++) do_req(1, 1'b1, 10'(a), pat(10'(a)), 4'hF);

    // reset hold with both ports requesting
    rst_n = 0; req_valid = 2'b11; req_write = 2'b00;
    for (int c = 0; c < 3; c++) begin
      post(0, 0, 0); post(1, 1, 0); post(2, 2, 0); post(3, 3, 0);
      step();
    end
    clear_lits();
    rst_n = 1; req_valid = 2'b00;
    do_read_lit(0, 10'h004, 32'hC0DE0004);

    // contention: continuous reads on both ports
    req_valid = 2'b11; req_write = 2'b00; req_addr[0] = 10'h005; req_addr[1] = 10'h006;
    for (int k = 0; k < 8; k++) begin
`ifdef BRAM_ARB_RR_EN
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
      want = 2'b10;
`endif
      post(0, 0, 32'(want[0])); post(1, 1, 32'(want[1]));
      step();
    end
    req_valid = 2'b00; clear_lits();
    step();

    // byte enables
    do_req(1, 1'b1, 10'h010, 32'h11223344, 4'b1111);
    do_req(1, 1'b1, 10'h010, 32'hAABBCCDD, 4'b0101);
    do_read_lit(0, 10'h010, 32'h11BB33DD);

    // backpressure on port 0 while port 1 keeps writing
    do_req(1, 1'b1, 10'h020, 32'hDEADBEEF, 4'hF);
    rsp_ready[0] = 0;
    do_req(0, 1'b0, 10'h020, 32'h0, 4'h0);
    req_valid[0] = 1; req_write[0] = 0; req_addr[0] = 10'h021;
    for (int k = 0; k < 5; k++) begin
      req_valid[1] = 1; req_write[1] = 1; req_addr[1] = 10'(10'h100 + k);
      req_data[1] = $urandom; req_be[1] = 4'hF;
      post(0, 0, 0); post(1, 1, 1); post(2, 4, 32'hDEADBEEF); post(3, 2, 1);
      step();
    end
    rsp_ready[0] = 1; req_valid[1] = 0;
    clear_lits();
    post(0, 0, 1); post(1, 4, 32'hDEADBEEF); post(2, 2, 1);
    step();
    req_valid[0] = 0; clear_lits();
    post(0, 2, 1); post(1, 4, 32'hC0DE0021);
    step();
    clear_lits();

    // read-after-write across ports
    do_req(1, 1'b1, 10'h3FF, 32'h0000CAFE, 4'hF);
    do_read_lit(0, 10'h3FF, 32'h0000CAFE);

    // reset mid-operation
    do_req(1, 1'b0, 10'h030, 32'h0, 4'h0);
    rst_n = 0;
    post(0, 3, 1); post(1, 5, pat(10'h030));
    step();
    rst_n = 1; clear_lits();
    for (int c = 0; c < 3; c++) begin
      post(0, 3, 0); post(1, 5, 0);
      step();
    end
    clear_lits();

    // randomized traffic; a stalled request is held unchanged until accepted
    pend = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          req_valid[p] = ($urandom_range(0, 3) != 0);
          req_write[p] = 1'($urandom_range(0, 1));
          req_addr[p]  = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 31));
          req_data[p]  = $urandom;
          req_be[p]    = 4'($urandom);
        end
        rsp_ready[p] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      acc = req_ready & req_valid;
      step();
      pend = req_valid & ~acc;
    end
    req_valid = 2'b00; rsp_ready = 2'b11;
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bram_arb2_rv.md
# bram_arb2_rv

Two-port, ready/valid block RAM for the core's shared program/data memory. It sits between the instruction-fetch unit (port 0) and the load/store and vector-load unit (port 1). Each cycle it arbitrates a single BRAM access between the two ports. Each port has a decoupled response channel that holds read data under backpressure, so a stalled consumer never loses a word and never blocks the other port's writes.

## Interface
Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 10, word-address width; depth = 2**ADDR_WIDTH words.

Ports (x = 0, 1; one set per port):
- i_clk  in  1  sole clock; all state changes on its rising edge.
- i_rst_n  in  1  reset, synchronous and active-low.
- i_req_valid_x  in  1  port x presents a request.
- o_req_ready_x  out  1  port x request accepted this cycle when high together with i_req_valid_x.
- i_req_write_x  in  1  1 = write, 0 = read.
- i_req_addr_x  in  ADDR_WIDTH  word address.
- i_req_data_x  in  DATA_WIDTH  write data.
- i_req_be_x  in  DATA_WIDTH/8  byte write enables; bit k covers bits [8k+7:8k].
- o_rsp_valid_x  out  1  read data available on port x.
- i_rsp_ready_x  in  1  port x consumer takes the response.
- o_rsp_data_x  out  DATA_WIDTH  read data.

## Operation
- Storage: 2**ADDR_WIDTH words. Reset does not clear contents.
- Eligibility:
  - A write is eligible whenever valid.
  - A read is eligible only if port x's response slot is empty, or is being drained this cycle (o_rsp_valid_x & i_rsp_ready_x).
- Arbitration:
  - At most one eligible port is granted per cycle; o_req_ready_x = grant_x.
  - Ready depends only on valid, write, slot state and i_rsp_ready_x.
  - Ready never depends on address or data.
- Grant policy when both ports are eligible is set by the macro in Configuration. A single eligible port is always granted.
- Write: bytes with i_req_be_x[k]=1 are updated at the acceptance edge; the other bytes are kept. Writes produce no response. A write with be = 0 is accepted and changes nothing.
- Read: the word is fetched at the acceptance edge and lands in port x's one-entry response slot.
- Response slot:
  - o_rsp_valid_x stays high, and o_rsp_data_x stays stable, until i_rsp_ready_x is sampled high.
  - Each port has at most one outstanding read.
- Responses are returned in request order per port. The two ports are independent; port x's backpressure never stalls port y.
- Reset (i_rst_n=0 at an edge):
  - Both slots are emptied.
  - The arbitration pointer is set to "port 1 last granted".
  - Both o_req_ready_x are 0 while i_rst_n=0, so no access occurs in a reset cycle.
  - A read accepted in the cycle before reset is discarded.

## Timing
- Reset values: o_req_ready_x=0, o_rsp_valid_x=0, o_rsp_data_x=0.
- Read latency: a request accepted at edge N gives o_rsp_valid_x=1 with data in the cycle following edge N (one cycle).
- Throughput: with i_rsp_ready_x held high and no contention, one read per cycle per port. Back-to-back reads are accepted in consecutive cycles.
- Read-after-write: a write accepted at edge N followed by a read of the same address accepted at edge N+1 (either port) returns the new data.
- Contention: the losing port sees o_req_ready=0 and must hold its request stable until accepted. Under round-robin it is granted no later than the next cycle.
- Address wrap: none; addresses are word-indexed and every value is in range.

## Configuration
- BRAM_ARB_RR_EN defined:
  - Round-robin between ports; the port not granted last wins a tie.
  - The pointer updates only on a grant made while both ports were eligible.
- BRAM_ARB_RR_EN undefined:
  - Fixed priority; port 1 (data) always wins a tie.
  - Port 0 may starve while port 1 stays eligible.
- All other behaviour is identical in both builds.

## Test plan
- Reset hold: i_rst_n=0 for 3 cycles with both i_req_valid=1 → o_req_ready_0/1=0 and o_rsp_valid_0/1=0 throughout. After release, the first read on port 0 of addr 0x004 returns the preloaded word one cycle after acceptance.
- Byte enables: port 1 writes 0x11223344 to 0x010 with be=4'b1111, then 0xAABBCCDD with be=4'b0101. A port 0 read of 0x010 then returns 0x11BB33DD.
- Backpressure: port 0 reads 0x020 (holds 0xDEADBEEF) with i_rsp_ready_0=0 for 5 cycles.
  - o_rsp_data_0 stays 0xDEADBEEF and further port 0 reads are not accepted.
  - Port 1 writes are accepted every cycle.
  - Once i_rsp_ready_0=1, the response is taken and the next port 0 read is accepted in that same cycle.
- Contention:
  - Both ports issue reads continuously. With BRAM_ARB_RR_EN, grants alternate 0,1,0,1 starting with port 0 after reset.
  - Without the macro, port 1 wins every tie and port 0 is granted only when port 1 is idle.
- Read-after-write across ports: port 1 writes 0x0000CAFE to 0x3FF at edge N and port 0 reads 0x3FF at edge N+1 → 0x0000CAFE.
- Reset mid-operation: a port 1 read is accepted, then i_rst_n=0 at the next edge → o_rsp_valid_1 is 0 after that edge, and no stale response appears after release.
